// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and register-address type for the
//               scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_scoreboard
// Description : Pending-write (busy) tracking for the register file.
//               Holds the busy bit-vector, WAW issue stall and a registered
//               population count of busy bits.
//               Optional macro REGFILE_BYPASS_EN: a same-cycle writeback
//               hides the busy bit from the read ports and lets an issue to
//               that register through.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb_scoreboard import regfile_pkg::*; #(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    output logic          busy1,
    output logic          busy2,
    output logic          iss_ready,
    output logic [AW:0]   busy_cnt
);

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             set_eff;
    logic             clr_eff;
    logic             cnt_inc;
    logic             cnt_dec;

    // Issue acceptance, effective set/clear and next busy vector
    always_comb begin
        busy_nxt = busy;
`ifdef REGFILE_BYPASS_EN
        iss_ready = !((iss_rd != '0) && busy[iss_rd] && !(we && (wa == iss_rd)));
`else
        iss_ready = !((iss_rd != '0) && busy[iss_rd]);
`endif
        set_eff = iss_valid && iss_ready && (iss_rd != '0);
        clr_eff = we && (wa != '0) && busy[wa];
        // Count tracks actual 0->1 and 1->0 transitions so it stays equal
        // to the popcount; a set on the register being cleared wins.
        cnt_inc = set_eff && !busy[iss_rd];
        cnt_dec = clr_eff && !(set_eff && (iss_rd == wa));
        if (clr_eff) busy_nxt[wa] = 1'b0;
        if (set_eff) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Busy vector and its counter
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (cnt_inc && !cnt_dec)
                busy_cnt <= busy_cnt + CNT_ONE;
            else if (cnt_dec && !cnt_inc)
                busy_cnt <= busy_cnt - CNT_ONE;
        end
    end

    // Busy status seen by the read ports
    always_comb begin
        busy1 = busy[ra1];
        busy2 = busy[ra2];
`ifdef REGFILE_BYPASS_EN
        if (we && (wa == ra1)) busy1 = 1'b0;
        if (we && (wa == ra2)) busy2 = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Two-read, one-write register file with x0 hardwired to zero
//               and a busy scoreboard for in-flight destinations.
//               Optional macro REGFILE_BYPASS_EN: forwards writeback data to
//               a matching read port in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb import regfile_pkg::*; #(
    parameter  int XLEN  = XLEN_DEFAULT,
    parameter  int NREGS = NREGS_DEFAULT,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] regs [NREGS];

    // Data array: register 0 is never written, so it stays zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Read muxes with x0 forced to zero
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : regs[ra1];
        rd2 = (ra2 == '0) ? '0 : regs[ra2];
`ifdef REGFILE_BYPASS_EN
        if (we && (wa == ra1) && (ra1 != '0)) rd1 = wd;
        if (we && (wa == ra2) && (ra2 != '0)) rd2 = wd;
`endif
    end

    regfile_sb_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .ra1       (ra1),
        .ra2       (ra2),
        .we        (we),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy1     (busy1),
        .busy2     (busy2),
        .iss_ready (iss_ready),
        .busy_cnt  (busy_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed self-checking bench for regfile_sb, default 32x32
//               instance plus a 64-bit x 16-register instance.
//               Expectations follow REGFILE_BYPASS_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1, ra2, wa, iss_rd;
    logic [31:0] rd1, rd2, wd;
    logic        busy1, busy2, we, iss_valid, iss_ready;
    logic [5:0]  busy_cnt;

    logic [3:0]  b_ra1, b_ra2, b_wa, b_iss_rd;
    logic [63:0] b_rd1, b_rd2, b_wd;
    logic        b_busy1, b_busy2, b_we, b_iss_valid, b_iss_ready;
    logic [4:0]  b_busy_cnt;

    int checks = 0;
    int passed = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_sb dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .busy_cnt(busy_cnt)
    );

    regfile_sb #(.XLEN(64), .NREGS(16)) dut_w (
        .clk(clk), .rst(rst), .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
        .busy1(b_busy1), .busy2(b_busy2), .we(b_we), .wa(b_wa), .wd(b_wd),
        .iss_valid(b_iss_valid), .iss_rd(b_iss_rd), .iss_ready(b_iss_ready),
        .busy_cnt(b_busy_cnt)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; iss_valid = 1'b0; b_we = 1'b0; b_iss_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        tick(); tick();
        rst = 1'b0;
        ra1 = 5'd5; ra2 = 5'd9; iss_rd = 5'd7;
        #1;
        checks++; if ({rd1, rd2} !== 64'h0) $display("FAIL reset_rd: got %h expected 0", {rd1, rd2}); else passed++;
        checks++; if ({busy1, busy2} !== 2'b00) $display("FAIL reset_busy: got %b expected 00", {busy1, busy2}); else passed++;
        checks++; if (iss_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", iss_ready); else passed++;
        checks++; if (busy_cnt !== 6'd0) $display("FAIL reset_cnt: got %0d expected 0", busy_cnt); else passed++;
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        we = 1'b0; ra1 = 5'd5;
        #1;
        checks++; if (rd1 !== 32'hDEADBEEF) $display("FAIL wr_x5: got %h expected deadbeef", rd1); else passed++;
        checks++; if (busy1 !== 1'b0) $display("FAIL wr_x5_busy: got %b expected 0", busy1); else passed++;
        checks++; if (busy_cnt !== 6'd0) $display("FAIL wr_nonbusy_cnt: got %0d expected 0", busy_cnt); else passed++;
        we = 1'b1; wa = 5'd0; wd = 32'h1;
        tick();
        we = 1'b0; ra1 = 5'd0;
        #1;
        checks++; if (rd1 !== 32'h0) $display("FAIL wr_x0: got %h expected 0", rd1); else passed++;
    endtask

    task automatic test_issue();
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        checks++; if (iss_ready !== 1'b1) $display("FAIL iss7_ready: got %b expected 1", iss_ready); else passed++;
        tick();
        iss_valid = 1'b0; ra1 = 5'd7;
        #1;
        checks++; if (busy1 !== 1'b1) $display("FAIL iss7_busy: got %b expected 1", busy1); else passed++;
        checks++; if (busy_cnt !== 6'd1) $display("FAIL iss7_cnt: got %0d expected 1", busy_cnt); else passed++;
        iss_valid = 1'b1;
        #1;
        checks++; if (iss_ready !== 1'b0) $display("FAIL waw_stall: got %b expected 0", iss_ready); else passed++;
        tick();
        iss_valid = 1'b0;
        #1;
        checks++; if (busy_cnt !== 6'd1) $display("FAIL stall_cnt: got %0d expected 1", busy_cnt); else passed++;
        we = 1'b1; wa = 5'd7; wd = 32'h55;
        tick();
        we = 1'b0;
        #1;
        checks++; if (busy_cnt !== 6'd0) $display("FAIL wb7_cnt: got %0d expected 0", busy_cnt); else passed++;
        checks++; if ({busy1, rd1} !== {1'b0, 32'h55}) $display("FAIL wb7_rd: got %b/%h expected 0/55", busy1, rd1); else passed++;
        iss_valid = 1'b1;
        #1;
        checks++; if (iss_ready !== 1'b1) $display("FAIL reiss7_ready: got %b expected 1", iss_ready); else passed++;
        tick();
        iss_valid = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'h66;
        tick();
        we = 1'b0;
        #1;
        checks++; if (busy_cnt !== 6'd0) $display("FAIL reiss7_clr_cnt: got %0d expected 0", busy_cnt); else passed++;
    endtask

    task automatic test_same_cycle();
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_valid = 1'b0; ra1 = 5'd3;
        // Write-clear and issue-set of busy x3 in one cycle
        we = 1'b1; wa = 5'd3; wd = 32'hA5A5; iss_valid = 1'b1; iss_rd = 5'd3;
        #1;
        checks++; if (iss_ready !== BYP) $display("FAIL same_ready: got %b expected %b", iss_ready, BYP); else passed++;
        tick();
        idle();
        #1;
        checks++; if (busy1 !== BYP) $display("FAIL same_busy: got %b expected %b", busy1, BYP); else passed++;
        checks++; if (rd1 !== 32'hA5A5) $display("FAIL same_data: got %h expected a5a5", rd1); else passed++;
        checks++; if (busy_cnt !== (BYP ? 6'd1 : 6'd0)) $display("FAIL same_cnt: got %0d expected %0d", busy_cnt, BYP ? 1 : 0); else passed++;
        we = 1'b1; wa = 5'd3; wd = 32'h0;
        tick();
        // Write and issue to non-busy x3 together: set wins, count +1
        we = 1'b1; wa = 5'd3; wd = 32'h77; iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        idle();
        #1;
        checks++; if ({busy1, rd1} !== {1'b1, 32'h77}) $display("FAIL setwins: got %b/%h expected 1/77", busy1, rd1); else passed++;
        checks++; if (busy_cnt !== 6'd1) $display("FAIL setwins_cnt: got %0d expected 1", busy_cnt); else passed++;
        we = 1'b1; wa = 5'd3;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        // Clear x4 and set x6 in the same cycle: net count change 0
        we = 1'b1; wa = 5'd4; wd = 32'h4; iss_rd = 5'd6;
        tick();
        idle();
        ra1 = 5'd4; ra2 = 5'd6;
        #1;
        checks++; if ({busy1, busy2} !== 2'b01) $display("FAIL b2b_busy: got %b expected 01", {busy1, busy2}); else passed++;
        checks++; if (busy_cnt !== 6'd1) $display("FAIL b2b_cnt: got %0d expected 1", busy_cnt); else passed++;
        // Issue of x0 always accepted, no state change
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        checks++; if (iss_ready !== 1'b1) $display("FAIL x0_iss_ready: got %b expected 1", iss_ready); else passed++;
        tick();
        iss_valid = 1'b0; we = 1'b1; wa = 5'd6;
        tick();
        idle();
        #1;
        checks++; if (busy_cnt !== 6'd0) $display("FAIL b2b_end_cnt: got %0d expected 0", busy_cnt); else passed++;
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd9; wd = 32'h1111;
        tick();
        we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        we = 1'b1; wa = 5'd9; wd = 32'h1234; ra2 = 5'd9; iss_rd = 5'd9;
        #1;
        checks++; if (rd2 !== (BYP ? 32'h1234 : 32'h1111)) $display("FAIL byp_rd2: got %h expected %h", rd2, BYP ? 32'h1234 : 32'h1111); else passed++;
        checks++; if (busy2 !== !BYP) $display("FAIL byp_busy2: got %b expected %b", busy2, !BYP); else passed++;
        checks++; if (iss_ready !== BYP) $display("FAIL byp_ready: got %b expected %b", iss_ready, BYP); else passed++;
        tick();
        we = 1'b0;
        #1;
        checks++; if ({busy2, rd2} !== {1'b0, 32'h1234}) $display("FAIL byp_after: got %b/%h expected 0/1234", busy2, rd2); else passed++;
    endtask

    task automatic test_reset_mid();
        iss_valid = 1'b1;
        for (int i = 10; i < 20; i++) begin
            iss_rd = 5'(i);
            tick();
        end
        iss_valid = 1'b0;
        #1;
        checks++; if (busy_cnt !== 6'd10) $display("FAIL fill10_cnt: got %0d expected 10", busy_cnt); else passed++;
        rst = 1'b1; we = 1'b1; wa = 5'd12; wd = 32'hFF; iss_valid = 1'b1; iss_rd = 5'd20;
        tick();
        rst = 1'b0; idle();
        ra1 = 5'd12; ra2 = 5'd5;
        #1;
        checks++; if (busy_cnt !== 6'd0) $display("FAIL rstmid_cnt: got %0d expected 0", busy_cnt); else passed++;
        checks++; if (iss_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", iss_ready); else passed++;
        checks++; if ({rd1, rd2} !== 64'h0) $display("FAIL rstmid_rd: got %h expected 0", {rd1, rd2}); else passed++;
        checks++; if (busy1 !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy1); else passed++;
    endtask

    task automatic test_wide();
        b_we = 1'b1; b_wa = 4'd15; b_wd = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        b_we = 1'b0; b_ra1 = 4'd15; b_ra2 = 4'd0;
        #1;
        checks++; if (b_rd1 !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wide_rd: got %h expected all ones", b_rd1); else passed++;
        checks++; if (b_rd2 !== 64'h0) $display("FAIL wide_x0: got %h expected 0", b_rd2); else passed++;
        b_iss_valid = 1'b1;
        for (int i = 1; i < 16; i++) begin
            b_iss_rd = 4'(i);
            tick();
        end
        b_iss_rd = 4'd0;
        tick();
        b_iss_valid = 1'b0;
        #1;
        checks++; if (b_busy_cnt !== 5'd15) $display("FAIL wide_full_cnt: got %0d expected 15", b_busy_cnt); else passed++;
        checks++; if (b_busy1 !== 1'b1) $display("FAIL wide_busy15: got %b expected 1", b_busy1); else passed++;
        b_iss_valid = 1'b1; b_iss_rd = 4'd15;
        #1;
        checks++; if (b_iss_ready !== 1'b0) $display("FAIL wide_stall: got %b expected 0", b_iss_ready); else passed++;
        tick();
        b_iss_valid = 1'b0;
        #1;
        checks++; if (b_busy_cnt !== 5'd15) $display("FAIL wide_no_ovf: got %0d expected 15", b_busy_cnt); else passed++;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; iss_rd = '0;
        b_ra1 = '0; b_ra2 = '0; b_wa = '0; b_wd = '0; b_iss_rd = '0;
        idle();
        test_reset();
        test_write_read();
        test_issue();
        test_same_cycle();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        test_wide();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
